// File: rtl/edge_bit_packer.sv
// Packs a 1-bit pixel stream LSB-first into 8-bit words, flushing a zero-padded
// partial word at the end of every image line and presenting words on valid/ready.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_EMPTY | no word held; word_valid_o low, bits always accepted
// ST_FULL  | word_out_o holds an unconsumed word; bits accepted only
//          | when the sink takes the held word in the same cycle
module edge_bit_packer #(
  parameter int IMG_WIDTH = 16,
  parameter int COL_W     = 12
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       enb_i,
  input  logic       bit_in_i,
  input  logic       bit_valid_i,
  output logic       bit_ready_o,
  output logic [7:0] word_out_o,
  output logic       word_valid_o,
  input  logic       word_ready_i,
  output logic       word_last_o,
  output logic       line_done_o
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);

  state_e           state_q, state_d;
  logic [7:0]       acc_q, acc_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [COL_W-1:0] col_cnt_q, col_cnt_d;
  logic [7:0]       word_q, word_d;
  logic             last_q, last_d;
  logic             line_done_q, line_done_d;

  logic       bit_acc;
  logic       word_acc;
  logic       col_end;
  logic       bit_end;
  logic       complete;
  logic [7:0] merged;

  // Ready depends only on held state and the sink, never on bit_valid_i.
  assign bit_ready_o = (state_q == ST_EMPTY) | word_ready_i;

  assign bit_acc  = enb_i & bit_valid_i & bit_ready_o;
  assign word_acc = enb_i & (state_q == ST_FULL) & word_ready_i;
  assign col_end  = (col_cnt_q == COL_LAST);
  assign bit_end  = (bit_cnt_q == 3'd7);
  assign complete = bit_acc & (bit_end | col_end);

  // Accumulator positions at and above bit_cnt_q are always zero here.
  assign merged = acc_q | (8'(bit_in_i) << bit_cnt_q);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    bit_cnt_d   = bit_cnt_q;
    col_cnt_d   = col_cnt_q;
    word_d      = word_q;
    last_d      = last_q;
    line_done_d = 1'b0;

    if (bit_acc) begin
      if (complete) begin
        acc_d     = '0;
        bit_cnt_d = '0;
        word_d    = merged;
        last_d    = col_end;
      end else begin
        acc_d     = merged;
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      col_cnt_d   = col_end ? '0 : (col_cnt_q + COL_ONE);
      line_done_d = col_end;
    end

    case (state_q)
      ST_EMPTY: begin
        if (complete) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (word_acc && !complete) begin
          state_d = ST_EMPTY;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= ST_EMPTY;
      acc_q       <= '0;
      bit_cnt_q   <= '0;
      col_cnt_q   <= '0;
      word_q      <= '0;
      last_q      <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      bit_cnt_q   <= bit_cnt_d;
      col_cnt_q   <= col_cnt_d;
      word_q      <= word_d;
      last_q      <= last_d;
      line_done_q <= line_done_d;
    end
  end

  assign word_valid_o = (state_q == ST_FULL);
  assign word_out_o   = word_q;
  assign word_last_o  = last_q;
  // The pulse is suppressed while the block is disabled.
  assign line_done_o  = line_done_q & enb_i;

endmodule
